tcm_rammaster: RTL and testbench

Initiator end of the TCM RAM port: converts a simple valid/ready request stream from a core-side load/store unit into RAM-port master transactions toward the parity-protected TCM RAM slave. Generates per-byte parity on writes, honours the slave's read wait-cycle backpressure (ready low after each read), and returns read data with an optional parity check. Sits between the core's TCM load/store path and the TCM RAM slave, one instance per TCM port.

---
 rtl/tcm_rammaster.sv | 159 +++++++++++++++
 tb/tb_tcm_rammaster.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_rammaster.sv
// tcm_rammaster: core-side request stream to TCM RAM-port master, with write parity.
// Optional read parity check and error counter: define TCM_PARITY_CHK_EN.
module tcm_rammaster #(
    parameter int AW  = 13,
    parameter int DW  = 32,
    parameter int PCW = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DW/8-1:0]      req_be,
    input  logic [AW-1:0]        req_addr,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_perr,
    output logic [PCW-1:0]       perr_cnt,
    output logic                 ramen,
    output logic                 ramcs,
    output logic [AW-1:0]        ramaddr,
    output logic [DW/8-1:0]      ramwr,
    output logic [DW+DW/8-1:0]   ramwdata,
    input  logic [DW+DW/8-1:0]   ramrdata,
    input  logic                 ramready
);

    localparam int BC = DW / 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            issue;
    logic [DW+BC-1:0] wlanes;
    logic [DW-1:0]   rd_strip;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   rdata_d;

    assign ramen = 1'b1;

    // Pack write bytes with even parity; strip parity from read lanes.
    always_comb begin
        wlanes   = '0;
        rd_strip = '0;
        for (int i = 0; i < BC; i++) begin
            wlanes[9*i+1 +: 8]  = req_wdata[8*i +: 8];
            wlanes[9*i]         = ^req_wdata[8*i +: 8];
            rd_strip[8*i +: 8]  = ramrdata[9*i+1 +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a read accept opens RD_WAIT; completion closes it unless
    // a new read is accepted in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !req_we) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ramready) begin
                    state_d = (accept && !req_we) ? RD_WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake, combinational RAM-port drive, response strobe.
    always_comb begin
        req_ready = resetn & ramready;
        accept    = req_valid & req_ready;
        issue     = accept & ~(req_we & ~|req_be);
        ramcs     = issue;
        ramaddr   = issue ? req_addr : '0;
        ramwr     = (issue && req_we) ? req_be : '0;
        ramwdata  = (issue && req_we) ? wlanes : '0;
        rsp_valid = resetn & (state_q == RD_WAIT) & ramready;
    end

    // Read data hold value: updated on each response.
    always_comb begin
        rdata_d = rsp_valid ? rd_strip : rdata_q;
    end

    // Read data hold register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rsp_rdata = rsp_valid ? rd_strip : rdata_q;

`ifdef TCM_PARITY_CHK_EN
    logic           perr_now;
    logic           perr_q;
    logic           perr_d;
    logic [PCW-1:0] cnt_q;
    logic [PCW-1:0] cnt_d;

    // Any lane with odd parity across byte+parity bit is an error.
    always_comb begin
        perr_now = 1'b0;
        for (int i = 0; i < BC; i++) begin
            perr_now = perr_now | (^ramrdata[9*i +: 9]);
        end
    end

    // Hold error flag per response; saturating error count.
    always_comb begin
        perr_d = rsp_valid ? perr_now : perr_q;
        cnt_d  = cnt_q;
        if (rsp_valid && perr_now && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Parity error state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perr_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            perr_q <= perr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rsp_perr = rsp_valid ? perr_now : perr_q;
    assign perr_cnt = cnt_q;
`else
    logic unused_par;

    assign unused_par = ^ramrdata;
    assign rsp_perr   = 1'b0;
    assign perr_cnt   = '0;
`endif

endmodule

// File: tb/tb_tcm_rammaster.sv
// tb_tcm_rammaster: directed bench for tcm_rammaster with a behavioural RAM slave.
// Parity-check expectations follow TCM_PARITY_CHK_EN.
module tb_tcm_rammaster;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int BC  = 4;
    localparam int PCW = 8;
    localparam int LW  = DW + BC;

    logic           clk = 1'b0;
    logic           resetn;
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [BC-1:0]  req_be;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_perr;
    logic [PCW-1:0] perr_cnt;
    logic           ramen;
    logic           ramcs;
    logic [AW-1:0]  ramaddr;
    logic [BC-1:0]  ramwr;
    logic [LW-1:0]  ramwdata;
    logic [LW-1:0]  ramrdata;
    logic           ramready;

    logic [LW-1:0]  mem [0:(1<<AW)-1];
    logic [LW-1:0]  rd_q = '0;
    logic [LW-1:0]  flip = '0;
    logic [LW-1:0]  exp_w;
    logic           exp_perr;
    logic [PCW-1:0] exp_cnt1;
    logic [PCW-1:0] exp_sat;

    int total = 0;
    int bad = 0;

    tcm_rammaster #(.AW(AW), .DW(DW), .PCW(PCW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
        .perr_cnt(perr_cnt), .ramen(ramen), .ramcs(ramcs), .ramaddr(ramaddr),
        .ramwr(ramwr), .ramwdata(ramwdata), .ramrdata(ramrdata),
        .ramready(ramready)
    );

    always #5 clk = ~clk;

    assign ramrdata = rd_q ^ flip;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (ramcs && ramready) begin
            if (ramwr == '0) begin
                rd_q <= mem[ramaddr];
            end else begin
                for (int i = 0; i < BC; i++)
                    if (ramwr[i]) mem[ramaddr][9*i +: 9] <= ramwdata[9*i +: 9];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [BC-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        ramready = 1'b1;
        drive(0, 0, 0, 0, 0);
        step;
        step;
        smp;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (ramcs !== 1'b0) begin bad++; $display("FAIL rst_ramcs got=%b want=0", ramcs); end
        total++; if (ramwr !== 4'h0) begin bad++; $display("FAIL rst_ramwr got=%h want=0", ramwr); end
        total++; if (ramaddr !== 13'h0) begin bad++; $display("FAIL rst_ramaddr got=%h want=0", ramaddr); end
        total++; if (ramwdata !== 36'h0) begin bad++; $display("FAIL rst_ramwdata got=%h want=0", ramwdata); end
        total++; if (ramen !== 1'b1) begin bad++; $display("FAIL rst_ramen got=%b want=1", ramen); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_perr !== 1'b0) begin bad++; $display("FAIL rst_perr got=%b want=0", rsp_perr); end
        total++; if (perr_cnt !== 8'h0) begin bad++; $display("FAIL rst_cnt got=%h want=0", perr_cnt); end
        step;
        resetn = 1'b1;
        smp;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rel_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_write;
        step;
        drive(1, 1, 4'hF, 13'h010, 32'hA5A5_0F0F);
        smp;
        exp_w = {9'h14A, 9'h14A, 9'h01E, 9'h01E};
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_req_ready got=%b want=1", req_ready); end
        total++; if (ramcs !== 1'b1) begin bad++; $display("FAIL wr_ramcs got=%b want=1", ramcs); end
        total++; if (ramwr !== 4'hF) begin bad++; $display("FAIL wr_ramwr got=%h want=f", ramwr); end
        total++; if (ramaddr !== 13'h010) begin bad++; $display("FAIL wr_ramaddr got=%h want=010", ramaddr); end
        total++; if (ramwdata !== exp_w) begin bad++; $display("FAIL wr_ramwdata got=%h want=%h", ramwdata, exp_w); end
    endtask

    task automatic test_read;
        step;
        drive(1, 0, 4'h0, 13'h010, 32'h0);
        smp;
        total++; if (ramcs !== 1'b1) begin bad++; $display("FAIL rd_ramcs got=%b want=1", ramcs); end
        total++; if (ramwr !== 4'h0) begin bad++; $display("FAIL rd_ramwr got=%h want=0", ramwr); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid got=%b want=0", rsp_valid); end
        step;
        drive(0, 0, 0, 0, 0);
        smp;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b want=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'hA5A5_0F0F) begin bad++; $display("FAIL rd_data got=%h want=a5a50f0f", rsp_rdata); end
        total++; if (rsp_perr !== 1'b0) begin bad++; $display("FAIL rd_perr got=%b want=0", rsp_perr); end
        step;
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'hA5A5_0F0F) begin bad++; $display("FAIL rd_hold got=%h want=a5a50f0f", rsp_rdata); end
    endtask

    task automatic test_wait;
        step;
        drive(1, 1, 4'hF, 13'h020, 32'h1234_5678);
        step;
        drive(1, 0, 4'h0, 13'h020, 32'h0);
        smp;
        step;
        ramready = 1'b0;
        drive(1, 0, 4'h0, 13'h010, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            smp;
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wait_valid_%0d got=%b want=0", k, rsp_valid); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wait_ready_%0d got=%b want=0", k, req_ready); end
            total++; if (ramcs !== 1'b0) begin bad++; $display("FAIL wait_ramcs_%0d got=%b want=0", k, ramcs); end
            step;
        end
        ramready = 1'b1;
        smp;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wait_done_valid got=%b want=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wait_data got=%h want=12345678", rsp_rdata); end
        total++; if (ramcs !== 1'b1) begin bad++; $display("FAIL wait_b2b_ramcs got=%b want=1", ramcs); end
        step;
        drive(0, 0, 0, 0, 0);
        smp;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wait_next_valid got=%b want=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'hA5A5_0F0F) begin bad++; $display("FAIL wait_next_data got=%h want=a5a50f0f", rsp_rdata); end
        step;
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wait_end_valid got=%b want=0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d;
        for (int a = 1; a <= 3; a++) begin
            step;
            d = 32'h1111_1111 * a;
            drive(1, 1, 4'hF, a[AW-1:0], d);
            smp;
            total++; if (ramcs !== 1'b1) begin bad++; $display("FAIL b2b_wr_cs_%0d got=%b want=1", a, ramcs); end
        end
        step;
        drive(1, 0, 4'h0, 13'd1, 32'h0);
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b want=0", rsp_valid); end
        for (int a = 2; a <= 4; a++) begin
            step;
            if (a <= 3) drive(1, 0, 4'h0, a[AW-1:0], 32'h0);
            else drive(0, 0, 0, 0, 0);
            smp;
            d = 32'h1111_1111 * (a - 1);
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_%0d got=%b want=1", a - 1, rsp_valid); end
            total++; if (rsp_rdata !== d) begin bad++; $display("FAIL b2b_data_%0d got=%h want=%h", a - 1, rsp_rdata, d); end
        end
        step;
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", rsp_valid); end
    endtask

    task automatic test_partial;
        step;
        drive(1, 1, 4'h2, 13'h030, 32'h0000_BB00);
        smp;
        exp_w = {9'h000, 9'h000, 9'h176, 9'h000};
        total++; if (ramwr !== 4'h2) begin bad++; $display("FAIL part_ramwr got=%h want=2", ramwr); end
        total++; if (ramwdata !== exp_w) begin bad++; $display("FAIL part_wdata got=%h want=%h", ramwdata, exp_w); end
        step;
        drive(1, 1, 4'h0, 13'h030, 32'hFFFF_FFFF);
        smp;
        total++; if (ramcs !== 1'b0) begin bad++; $display("FAIL be0_ramcs got=%b want=0", ramcs); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL be0_ready got=%b want=1", req_ready); end
        total++; if (ramwr !== 4'h0) begin bad++; $display("FAIL be0_ramwr got=%h want=0", ramwr); end
        step;
        drive(1, 0, 4'h0, 13'h030, 32'h0);
        step;
        drive(0, 0, 0, 0, 0);
        smp;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL part_rd_valid got=%b want=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0000_BB00) begin bad++; $display("FAIL part_rd_data got=%h want=0000bb00", rsp_rdata); end
    endtask

    task automatic test_parity;
`ifdef TCM_PARITY_CHK_EN
        exp_perr = 1'b1;
        exp_cnt1 = 8'h01;
        exp_sat  = 8'hFF;
`else
        exp_perr = 1'b0;
        exp_cnt1 = 8'h00;
        exp_sat  = 8'h00;
`endif
        flip = 36'h200;
        step;
        drive(1, 0, 4'h0, 13'h010, 32'h0);
        step;
        drive(0, 0, 0, 0, 0);
        smp;
        total++; if (rsp_perr !== exp_perr) begin bad++; $display("FAIL par_perr got=%b want=%b", rsp_perr, exp_perr); end
        total++; if (rsp_rdata !== 32'hA5A5_0F0F) begin bad++; $display("FAIL par_data got=%h want=a5a50f0f", rsp_rdata); end
        step;
        smp;
        total++; if (perr_cnt !== exp_cnt1) begin bad++; $display("FAIL par_cnt1 got=%h want=%h", perr_cnt, exp_cnt1); end
        total++; if (rsp_perr !== exp_perr) begin bad++; $display("FAIL par_hold got=%b want=%b", rsp_perr, exp_perr); end
        for (int n = 0; n < 300; n++) begin
            step;
            drive(1, 0, 4'h0, 13'h010, 32'h0);
        end
        step;
        drive(0, 0, 0, 0, 0);
        step;
        smp;
        total++; if (perr_cnt !== exp_sat) begin bad++; $display("FAIL par_sat got=%h want=%h", perr_cnt, exp_sat); end
        flip = '0;
    endtask

    task automatic test_reset_mid_read;
        step;
        drive(1, 0, 4'h0, 13'h010, 32'h0);
        step;
        ramready = 1'b0;
        drive(0, 0, 0, 0, 0);
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_wait_valid got=%b want=0", rsp_valid); end
        step;
        resetn = 1'b0;
        ramready = 1'b1;
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", rsp_valid); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", req_ready); end
        step;
        smp;
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", rsp_rdata); end
        total++; if (perr_cnt !== 8'h0) begin bad++; $display("FAIL mid_rst_cnt got=%h want=0", perr_cnt); end
        total++; if (rsp_perr !== 1'b0) begin bad++; $display("FAIL mid_rst_perr got=%b want=0", rsp_perr); end
        step;
        resetn = 1'b1;
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_valid got=%b want=0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b want=1", req_ready); end
        step;
        smp;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_valid2 got=%b want=0", rsp_valid); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_wait;
        test_back_to_back;
        test_partial;
        test_parity;
        test_reset_mid_read;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
